// File: rtl/bg_scene_ctrl_pkg.sv
// Shared types and constants for the background scene controller.
// The optional BG_SCROLL_EN macro enables horizontal scrolling in the users of this package.
package bg_ctrl_pkg;

   typedef enum logic [1:0] {
      SHOW     = 2'd0,
      FADE_OUT = 2'd1,
      SWAP     = 2'd2,
      FADE_IN  = 2'd3
   } bg_state_t;

   localparam int BG_W         = 300;
   localparam int BG_H         = 300;
   localparam int FADE_MAX     = 16;
   localparam int FADE_STEP    = 2;
   localparam int SCALE_X_MUL  = 15;
   localparam int SCALE_X_SHR  = 5;
   localparam int SCALE_Y_MUL  = 5;
   localparam int SCALE_Y_SHR  = 3;
   localparam int FRAME_TICK_Y = 480;

   localparam int ADDR_W   = 17;
   localparam int SRC_W    = 9;
   localparam int SCROLL_W = 9;
   localparam int FADE_W   = 5;

   // Row base for a 300-wide image: y*300 = y*(256+32+8+4), no multiplier.
   function automatic logic [ADDR_W-1:0] row_base(input logic [SRC_W-1:0] y);
      logic [ADDR_W-1:0] yw;
      yw = ADDR_W'(y);
      return (yw << 8) + (yw << 5) + (yw << 3) + (yw << 2);
   endfunction

endpackage

// File: rtl/bg_scene_ctrl_addr_gen.sv
// Raster-to-ROM address generator: scaling, scroll wrap, 2-stage address pipeline and blank delay.
// Scroll wrap adder exists only when BG_SCROLL_EN is defined.
module bg_addr_gen
   import bg_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [9:0]          draw_x,
   input  logic [9:0]          draw_y,
   input  logic                blank,
   input  logic [SCROLL_W-1:0] scroll_x,
   output logic [ADDR_W-1:0]   rom_address,
   output logic                blank_p3
);

   logic [13:0]       x_mul;
   logic [11:0]       y_mul;
   logic [SRC_W-1:0]  src_x_p1_d, src_x_p1_q;
   logic [SRC_W-1:0]  src_y_p1_d, src_y_p1_q;
   logic              blank_p1_q, blank_p2_q, blank_p3_q;
   logic [9:0]        col;
   logic [ADDR_W-1:0] rom_address_d, rom_address_q;

   always_comb begin
      x_mul      = 14'(draw_x) * 14'(SCALE_X_MUL);
      y_mul      = 12'(draw_y) * 12'(SCALE_Y_MUL);
      src_x_p1_d = SRC_W'(x_mul >> SCALE_X_SHR);
      src_y_p1_d = SRC_W'(y_mul >> SCALE_Y_SHR);
   end

`ifdef BG_SCROLL_EN
   logic [9:0] col_sum;

   always_comb begin
      col_sum = 10'(src_x_p1_q) + 10'(scroll_x);
      col     = col_sum;
      if (col_sum >= 10'(BG_W)) begin
         col = col_sum - 10'(BG_W);
      end
   end
`else
   logic unused_scroll_x;
   assign unused_scroll_x = ^scroll_x;

   always_comb begin
      col = 10'(src_x_p1_q);
   end
`endif

   always_comb begin
      rom_address_d = row_base(src_y_p1_q) + ADDR_W'(col);
   end

   // Stage 1: scaled source coordinates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_x_p1_q <= '0;
         src_y_p1_q <= '0;
         blank_p1_q <= 1'b0;
      end else begin
         src_x_p1_q <= src_x_p1_d;
         src_y_p1_q <= src_y_p1_d;
         blank_p1_q <= blank;
      end
   end

   // Stage 2: ROM address; stage 3 covers the ROM read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_address_q <= '0;
         blank_p2_q    <= 1'b0;
         blank_p3_q    <= 1'b0;
      end else begin
         rom_address_q <= rom_address_d;
         blank_p2_q    <= blank_p1_q;
         blank_p3_q    <= blank_p2_q;
      end
   end

   assign rom_address = rom_address_q;
   assign blank_p3    = blank_p3_q;

endmodule

// File: rtl/bg_scene_ctrl.sv
// Background scene controller: level-change FSM with fade out/swap/fade in, scroll offset, faded RGB output.
// Define BG_SCROLL_EN to enable per-frame horizontal scrolling; otherwise scroll_x is held at 0.
module bg_scene_ctrl
   import bg_ctrl_pkg::*;
(
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic [3:0]        scroll_speed,
   input  logic              level_req,
   input  logic [1:0]        level_sel,
   input  logic [3:0]        pal_red,
   input  logic [3:0]        pal_green,
   input  logic [3:0]        pal_blue,
   output logic [ADDR_W-1:0] rom_address,
   output logic [1:0]        bg_sel,
   output logic              busy,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue
);

   bg_state_t           state_d, state_q;
   logic [1:0]          pending_sel_d, pending_sel_q;
   logic [1:0]          bg_sel_d, bg_sel_q;
   logic [FADE_W-1:0]   fade_d, fade_q;
   logic [SCROLL_W-1:0] scroll_x;
   logic                frame_tick;
   logic                blank_p3;
   logic [3:0]          red_d, red_q;
   logic [3:0]          green_d, green_q;
   logic [3:0]          blue_d, blue_q;

   function automatic logic [3:0] fade_chan(input logic [3:0] c, input logic [FADE_W-1:0] f);
      logic [8:0] prod;
      prod = 9'(c) * 9'(f);
      return 4'(prod >> 4);
   endfunction

   assign frame_tick = (DrawX == 10'd0) && (DrawY == 10'(FRAME_TICK_Y));

   bg_addr_gen u_addr_gen (
      .clk         (vga_clk),
      .rst_n       (reset_n),
      .draw_x      (DrawX),
      .draw_y      (DrawY),
      .blank       (blank),
      .scroll_x    (scroll_x),
      .rom_address (rom_address),
      .blank_p3    (blank_p3)
   );

   // Fade steps on frame_tick only, so level changes never tear mid-frame.
   always_comb begin
      state_d       = state_q;
      pending_sel_d = pending_sel_q;
      bg_sel_d      = bg_sel_q;
      fade_d        = fade_q;
      case (state_q)
         SHOW: begin
            if (level_req && (level_sel != bg_sel_q)) begin
               pending_sel_d = level_sel;
               state_d       = FADE_OUT;
            end
         end
         FADE_OUT: begin
            if (frame_tick) begin
               if (fade_q <= FADE_W'(FADE_STEP)) begin
                  fade_d  = '0;
                  state_d = SWAP;
               end else begin
                  fade_d = fade_q - FADE_W'(FADE_STEP);
               end
            end
         end
         SWAP: begin
            bg_sel_d = pending_sel_q;
            state_d  = FADE_IN;
         end
         FADE_IN: begin
            if (frame_tick) begin
               if (fade_q >= FADE_W'(FADE_MAX - FADE_STEP)) begin
                  fade_d  = FADE_W'(FADE_MAX);
                  state_d = SHOW;
               end else begin
                  fade_d = fade_q + FADE_W'(FADE_STEP);
               end
            end
         end
         default: state_d = SHOW;
      endcase
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= SHOW;
         pending_sel_q <= 2'd0;
         bg_sel_q      <= 2'd0;
         fade_q        <= FADE_W'(FADE_MAX);
      end else begin
         state_q       <= state_d;
         pending_sel_q <= pending_sel_d;
         bg_sel_q      <= bg_sel_d;
         fade_q        <= fade_d;
      end
   end

`ifdef BG_SCROLL_EN
   logic [SCROLL_W-1:0] scroll_x_d, scroll_x_q;
   logic [9:0]          scroll_sum;

   always_comb begin
      scroll_sum = 10'(scroll_x_q) + 10'(scroll_speed);
      scroll_x_d = scroll_x_q;
      if (state_q == SWAP) begin
         scroll_x_d = '0;
      end else if ((state_q == SHOW) && frame_tick) begin
         if (scroll_sum >= 10'(BG_W)) begin
            scroll_x_d = SCROLL_W'(scroll_sum - 10'(BG_W));
         end else begin
            scroll_x_d = SCROLL_W'(scroll_sum);
         end
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         scroll_x_q <= '0;
      end else begin
         scroll_x_q <= scroll_x_d;
      end
   end

   assign scroll_x = scroll_x_q;
`else
   logic unused_scroll_speed;
   assign unused_scroll_speed = ^scroll_speed;
   assign scroll_x            = '0;
`endif

   always_comb begin
      red_d   = 4'd0;
      green_d = 4'd0;
      blue_d  = 4'd0;
      if (blank_p3) begin
         red_d   = fade_chan(pal_red, fade_q);
         green_d = fade_chan(pal_green, fade_q);
         blue_d  = fade_chan(pal_blue, fade_q);
      end
   end

   // Stage 4: faded, blanked RGB
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         red_q   <= 4'd0;
         green_q <= 4'd0;
         blue_q  <= 4'd0;
      end else begin
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
      end
   end

   assign bg_sel = bg_sel_q;
   assign busy   = (state_q != SHOW);
   assign red    = red_q;
   assign green  = green_q;
   assign blue   = blue_q;

endmodule

// File: tb/tb_bg_scene_ctrl.sv
// Directed bench for bg_scene_ctrl: address/colour vector table plus scroll and level-change sequences.
module tb_bg_scene_ctrl;

`ifdef BG_SCROLL_EN
   localparam bit SCROLL_ON = 1'b1;
`else
   localparam bit SCROLL_ON = 1'b0;
`endif

   logic        vga_clk;
   logic        reset_n;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        blank;
   logic [3:0]  scroll_speed;
   logic        level_req;
   logic [1:0]  level_sel;
   logic [3:0]  pal_red;
   logic [3:0]  pal_green;
   logic [3:0]  pal_blue;
   logic [16:0] rom_address;
   logic [1:0]  bg_sel;
   logic        busy;
   logic [3:0]  red;
   logic [3:0]  green;
   logic [3:0]  blue;

   int n_pass  = 0;
   int n_total = 0;

   bg_scene_ctrl dut (
      .vga_clk      (vga_clk),
      .reset_n      (reset_n),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .blank        (blank),
      .scroll_speed (scroll_speed),
      .level_req    (level_req),
      .level_sel    (level_sel),
      .pal_red      (pal_red),
      .pal_green    (pal_green),
      .pal_blue     (pal_blue),
      .rom_address  (rom_address),
      .bg_sel       (bg_sel),
      .busy         (busy),
      .red          (red),
      .green        (green),
      .blue         (blue)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        blk;
      logic [3:0]  pr;
      logic [3:0]  pg;
      logic [3:0]  pb;
      logic [16:0] addr;
      logic [3:0]  er;
      logic [3:0]  eg;
      logic [3:0]  eb;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(posedge vga_clk);
      #1;
   endtask

   // One-cycle frame_tick, then restore the raster position.
   task automatic frame_tick();
      logic [9:0] sx, sy;
      sx = DrawX;
      sy = DrawY;
      @(negedge vga_clk);
      DrawX = 10'd0;
      DrawY = 10'd480;
      @(negedge vga_clk);
      DrawX = sx;
      DrawY = sy;
   endtask

   task automatic pulse_req(input logic [1:0] sel);
      @(negedge vga_clk);
      level_req = 1'b1;
      level_sel = sel;
      @(posedge vga_clk);
      #1;
      level_req = 1'b0;
   endtask

   function automatic int faded(input int c, input int f);
      return (c * f) / 16;
   endfunction

   initial begin
      vecs[0] = '{10'd639, 10'd479, 1'b1, 4'd15, 4'd0,  4'd7,  17'd89999, 4'd15, 4'd0,  4'd7};
      vecs[1] = '{10'd0,   10'd0,   1'b1, 4'd15, 4'd15, 4'd15, 17'd0,     4'd15, 4'd15, 4'd15};
      vecs[2] = '{10'd320, 10'd240, 1'b1, 4'd8,  4'd3,  4'd12, 17'd45150, 4'd8,  4'd3,  4'd12};
      vecs[3] = '{10'd100, 10'd50,  1'b1, 4'd9,  4'd1,  4'd2,  17'd9346,  4'd9,  4'd1,  4'd2};
      vecs[4] = '{10'd639, 10'd0,   1'b0, 4'd15, 4'd15, 4'd15, 17'd299,   4'd0,  4'd0,  4'd0};
      vecs[5] = '{10'd1,   10'd1,   1'b1, 4'd0,  4'd5,  4'd10, 17'd0,     4'd0,  4'd5,  4'd10};
      vecs[6] = '{10'd33,  10'd8,   1'b1, 4'd5,  4'd14, 4'd1,  17'd1515,  4'd5,  4'd14, 4'd1};

      reset_n      = 1'b0;
      DrawX        = 10'd639;
      DrawY        = 10'd479;
      blank        = 1'b1;
      scroll_speed = 4'd0;
      level_req    = 1'b0;
      level_sel    = 2'd0;
      pal_red      = 4'd15;
      pal_green    = 4'd15;
      pal_blue     = 4'd15;
      cycles(3);
      chk("reset_addr", rom_address, 0);
      chk("reset_bg_sel", bg_sel, 0);
      chk("reset_busy", busy, 0);
      chk("reset_red", red, 0);

      @(negedge vga_clk);
      reset_n = 1'b1;
      cycles(2);
      chk("addr_latency2", rom_address, 89999);

      for (int i = 0; i < 7; i++) begin
         @(negedge vga_clk);
         DrawX     = vecs[i].x;
         DrawY     = vecs[i].y;
         blank     = vecs[i].blk;
         pal_red   = vecs[i].pr;
         pal_green = vecs[i].pg;
         pal_blue  = vecs[i].pb;
         cycles(4);
         chk($sformatf("vec%0d_addr", i), rom_address, vecs[i].addr);
         chk($sformatf("vec%0d_red", i), red, vecs[i].er);
         chk($sformatf("vec%0d_green", i), green, vecs[i].eg);
         chk($sformatf("vec%0d_blue", i), blue, vecs[i].eb);
      end

      // Blank latency: output must follow blank exactly four edges later.
      @(negedge vga_clk);
      pal_red = 4'd15;
      blank   = 1'b1;
      cycles(5);
      @(negedge vga_clk);
      blank = 1'b0;
      cycles(3);
      chk("blank_lat3_red", red, 15);
      cycles(1);
      chk("blank_lat4_red", red, 0);
      @(negedge vga_clk);
      blank = 1'b1;

      // Scroll: 100 ticks of 3 wraps to 0, 103 ticks gives 9.
      DrawX        = 10'd0;
      DrawY        = 10'd0;
      scroll_speed = 4'd3;
      for (int i = 0; i < 100; i++) frame_tick();
      cycles(3);
      chk("scroll_wrap0_addr", rom_address, 0);
      for (int i = 0; i < 3; i++) frame_tick();
      cycles(3);
      chk("scroll_103_addr", rom_address, SCROLL_ON ? 9 : 0);
      scroll_speed = 4'd1;
      frame_tick();
      @(negedge vga_clk);
      DrawX = 10'd639;
      DrawY = 10'd0;
      cycles(3);
      chk("scroll_col_wrap_addr", rom_address, SCROLL_ON ? 9 : 299);

      // Level change to 2 with an ignored request during fade-out.
      pulse_req(2'd2);
      chk("req_busy", busy, 1);
      chk("req_bg_sel_hold", bg_sel, 0);
      cycles(4);
      chk("fade16_red", red, 15);
      for (int i = 1; i <= 8; i++) begin
         frame_tick();
         if (i == 2) begin
            pulse_req(2'd1);
         end
         if (i == 8) begin
            chk("pre_swap_bg_sel", bg_sel, 0);
            cycles(1);
            chk("swap_bg_sel", bg_sel, 2);
            chk("swap_busy", busy, 1);
         end
         cycles(4);
         chk($sformatf("fade_out%0d_red", i), red, faded(15, 16 - 2 * i));
      end
      chk("scroll_reset_addr", rom_address, 299);
      for (int i = 1; i <= 8; i++) begin
         frame_tick();
         cycles(4);
         chk($sformatf("fade_in%0d_red", i), red, faded(15, 2 * i));
      end
      chk("done_busy", busy, 0);
      chk("done_bg_sel", bg_sel, 2);
      chk("scroll_hold_addr", rom_address, 299);

      // Same-selection request is ignored.
      pulse_req(2'd2);
      chk("same_sel_busy", busy, 0);

      // Reset in the middle of a fade-in.
      pulse_req(2'd1);
      for (int i = 0; i < 8; i++) frame_tick();
      cycles(2);
      chk("mid_bg_sel", bg_sel, 1);
      frame_tick();
      frame_tick();
      cycles(4);
      chk("mid_fade_in_red", red, faded(15, 4));
      @(negedge vga_clk);
      reset_n = 1'b0;
      #1;
      chk("async_rst_bg_sel", bg_sel, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_addr", rom_address, 0);
      @(negedge vga_clk);
      reset_n = 1'b1;
      cycles(5);
      chk("post_rst_red", red, 15);
      chk("post_rst_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
